// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM encodings,
// default operand width and the divide-by-zero quotient constant.
package muldiv_defs;

   localparam int XLEN_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   localparam logic [XLEN_DEF-1:0] DIV0_Q = '1;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. Purely combinational.
module muldiv_step
   import muldiv_defs::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            i_is_div,
   input  logic [XLEN-1:0] i_acc,
   input  logic [XLEN-1:0] i_sr,
   input  logic [XLEN-1:0] i_opnd,
   output logic [XLEN-1:0] o_acc,
   output logic [XLEN-1:0] o_sr
);

   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_shl;
   logic [XLEN-1:0] w_diff;
   logic            w_ge;

   always_comb begin
      w_sum  = {1'b0, i_acc} + (i_sr[0] ? {1'b0, i_opnd} : '0);
      w_shl  = {i_acc, i_sr[XLEN-1]};
      w_ge   = (w_shl >= {1'b0, i_opnd});
      // When w_ge holds the true difference is below 2^XLEN, so XLEN bits suffice.
      w_diff = w_shl[XLEN-1:0] - i_opnd;
      if (i_is_div) begin
         o_acc = w_ge ? w_diff : w_shl[XLEN-1:0];
         o_sr  = {i_sr[XLEN-2:0], w_ge};
      end else begin
         o_acc = w_sum[XLEN:1];
         o_sr  = {w_sum[0], i_sr[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MIPS32 multiply/divide unit owning HI/LO, with busy/done handshake.
// Optional MULDIV_EARLY_OUT_EN: multiply exits CALC once remaining multiplier bits are zero.
module muldiv_seq
   import muldiv_defs::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            mul0_div1_sel,
   input  logic            signed_op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            cancel,
   input  logic            we_hi,
   input  logic            we_lo,
   input  logic [XLEN-1:0] wd_hilo,
   output logic            busy,
   output logic            done,
   output logic            div_zero,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] L_DIV0_Q = XLEN'(DIV0_Q);

   function automatic logic [XLEN-1:0] neg_w(input logic n, input logic [XLEN-1:0] v);
      return n ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_2w(input logic n, input logic [2*XLEN-1:0] v);
      return n ? (~v + 1'b1) : v;
   endfunction

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic            r_done, r_div_zero;
   logic [XLEN-1:0] r_hi, r_lo;

   logic [XLEN-1:0] r_acc, r_sr, r_opnd;
   logic            r_is_div, r_neg_res, r_neg_rem;

   logic            w_accept, w_commit, w_early;
   logic            w_a_neg, w_b_neg;
   logic [XLEN-1:0] w_abs_a, w_abs_b;
   logic [XLEN-1:0] w_acc_nxt, w_sr_nxt;
   logic [2*XLEN-1:0] w_prod_al, w_prod;
   logic [XLEN-1:0] w_res_hi, w_res_lo;

   assign w_a_neg = signed_op & op_a[XLEN-1];
   assign w_b_neg = signed_op & op_b[XLEN-1];
   assign w_abs_a = neg_w(w_a_neg, op_a);
   assign w_abs_b = neg_w(w_b_neg, op_b);

   muldiv_step #(.XLEN(XLEN)) u_step (
      .i_is_div (r_is_div),
      .i_acc    (r_acc),
      .i_sr     (r_sr),
      .i_opnd   (r_opnd),
      .o_acc    (w_acc_nxt),
      .o_sr     (w_sr_nxt)
   );

`ifdef MULDIV_EARLY_OUT_EN
   // After step r_cnt, the low XLEN-1-r_cnt bits of the shift register are unconsumed multiplier.
   assign w_early   = !r_is_div &&
                      ((w_sr_nxt & ({XLEN{1'b1}} >> (r_cnt + CW'(1)))) == '0);
   assign w_prod_al = {r_acc, r_sr} >> (CW'(XLEN) - r_cnt);
`else
   assign w_early   = 1'b0;
   assign w_prod_al = {r_acc, r_sr};
`endif

   assign w_prod = neg_2w(r_neg_res, w_prod_al);

   always_comb begin
      w_res_hi = w_prod[2*XLEN-1:XLEN];
      w_res_lo = w_prod[XLEN-1:0];
      if (r_is_div) begin
         // Divide by zero leaves |a| as remainder; re-signing it restores raw op_a.
         w_res_hi = neg_w(r_neg_rem, r_acc);
         w_res_lo = r_div_zero ? L_DIV0_Q : neg_w(r_neg_res, r_sr);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !cancel) begin
               w_state_nxt = ST_CALC;
               w_accept    = 1'b1;
            end
         end
         ST_CALC: begin
            if (cancel)
               w_state_nxt = ST_IDLE;
            else if ((r_cnt == CW'(XLEN-1)) || w_early)
               w_state_nxt = ST_FIX;
         end
         ST_FIX: begin
            w_state_nxt = ST_IDLE;
            w_commit    = !cancel;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_commit;
         r_cnt   <= (r_state == ST_CALC) ? r_cnt + CW'(1) : '0;
         if (w_accept)
            r_div_zero <= mul0_div1_sel && (op_b == '0);
         if (r_state == ST_IDLE) begin
            if (we_hi) r_hi <= wd_hilo;
            if (we_lo) r_lo <= wd_hilo;
         end else if (w_commit) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_is_div  <= mul0_div1_sel;
         r_neg_res <= w_a_neg ^ w_b_neg;
         r_neg_rem <= w_a_neg;
         r_acc     <= '0;
         r_sr      <= mul0_div1_sel ? w_abs_a : w_abs_b;
         r_opnd    <= mul0_div1_sel ? w_abs_b : w_abs_a;
      end else if (r_state == ST_CALC) begin
         r_acc <= w_acc_nxt;
         r_sr  <= w_sr_nxt;
      end
   end

   assign busy     = (r_state != ST_IDLE);
   assign done     = r_done;
   assign div_zero = r_div_zero;
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule
